// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline-register chain and the hazard unit.
package pipe_pkg;

  localparam int DEF_CNT_W = 16;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid + payload register of the chain; a load always wins over a clear.
module pipe_stage #(
  parameter int WIDTH         = 64,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Stage register: load, clear (optionally zeroing payload) or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= {WIDTH{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
      if (CLEAR_PAYLOAD) begin
        q <= {WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready stall, per-stage flush,
// occupancy reporting and a saturating count of flushed live words.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 4,
  parameter bit CLEAR_PAYLOAD = 1'b1,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic [DEPTH-1:0]            flush,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [CNT_W-1:0]            flush_count
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] load_s;
  logic [DEPTH-1:0] clear_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [WIDTH-1:0] din_s  [DEPTH];
  logic [4:0]       occ_s;
  logic [4:0]       kill_s;
  logic [CNT_W+4:0] sum_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] flush_count_r;

  // Ready ripples from the output back to the input; a flushed stage is
  // always free because its resident word dies this edge.
  always_comb begin
    logic rdy;
    ready_s = {DEPTH{1'b0}};
    rdy     = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy        = ~valid_s[i] | rdy | flush[i];
      ready_s[i] = rdy;
    end
  end

  // Per-stage load source and clear; a flushed word never moves forward.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      din_s[i] = {WIDTH{1'b0}};
    end
    load_s    = {DEPTH{1'b0}};
    load_s[0] = in_valid & ready_s[0];
    din_s[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = valid_s[i-1] & ~flush[i-1] & ready_s[i];
      din_s[i]  = data_s[i-1];
    end
    clear_s = valid_s & ready_s & ~load_s;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH         (WIDTH),
      .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .load  (load_s[g]),
      .clear (clear_s[g]),
      .d     (din_s[g]),
      .valid (valid_s[g]),
      .q     (data_s[g])
    );
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[DEPTH-1] & ~flush[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];

  assign occ_s     = popcount16(16'(valid_s));
  assign occupancy = occ_s[OCC_W-1:0];
  assign kill_s    = popcount16(16'(flush & valid_s));

  // Saturating next value of the flush counter.
  always_comb begin
    sum_s = (CNT_W + 5)'(flush_count_r) + (CNT_W + 5)'(kill_s);
    if (sum_s > (CNT_W + 5)'({CNT_W{1'b1}})) begin
      cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      cnt_nxt_s = sum_s[CNT_W-1:0];
    end
  end

  // Flush counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count_r <= {CNT_W{1'b0}};
    end else begin
      flush_count_r <= cnt_nxt_s;
    end
  end

  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed scoreboard bench for pipe_reg_chain (DEPTH=4) plus a CNT_W=2 instance.
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  flush;
  logic [2:0]  occupancy;
  logic [15:0] flush_count;

  logic        v2;
  logic        rdy2;
  logic [7:0]  d2;
  logic        ov2;
  logic        or2;
  logic [7:0]  od2;
  logic [3:0]  f2;
  logic [2:0]  occ2;
  logic [1:0]  fc2;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] sb[$];
  logic [63:0] tmp;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(64), .DEPTH(4), .CLEAR_PAYLOAD(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .occupancy(occupancy),
    .flush_count(flush_count)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .CLEAR_PAYLOAD(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .out_valid(ov2), .out_ready(or2),
    .out_data(od2), .flush(f2), .occupancy(occ2),
    .flush_count(fc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan both handshakes mid-cycle, then advance one clock.
  task automatic tick();
    logic [63:0] exp;
    #2;
    if (out_valid && out_ready) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = {64{1'bx}};
      chk("out_data", out_data, exp);
    end
    if (in_valid && in_ready) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0; flush = 4'd0;
    v2 = 1'b0; d2 = 8'd0; or2 = 1'b0; f2 = 4'd0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_flush_count", 64'(flush_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Three words back to back, free-flowing output.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h11; tick();
    in_data = 64'h22; tick();
    in_data = 64'h33; tick();
    in_valid = 1'b0;
    #1;
    chk("occ_peak", 64'(occupancy), 64'd3);
    chk("lat_early", 64'(out_valid), 64'd0);
    tick();
    chk("lat_first", 64'(out_valid), 64'd1);
    chk("lat_data", out_data, 64'h11);
    for (int k = 0; k < 3; k++) tick();
    chk("drain1_occ", 64'(occupancy), 64'd0);
    chk("drain1_sb", 64'(sb.size()), 64'd0);

    // Fill, stall five cycles, release.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 64'h100 + 64'(k);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_occ", 64'(occupancy), 64'd4);
      chk("stall_data", out_data, 64'h100);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("drain2_occ", 64'(occupancy), 64'd0);
    chk("drain2_sb", 64'(sb.size()), 64'd0);

    // Stream A0..A7, kill the two youngest words mid-stream.
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 64'hA0 + 64'(k);
      tick();
    end
    in_valid = 1'b0;
    flush = 4'b0011;
    tmp = sb.pop_back();
    tmp = sb.pop_back();
    tick();
    flush = 4'b0000;
    chk("flush_cnt_2", 64'(flush_count), 64'd2);
    in_valid = 1'b1;
    for (int k = 5; k < 8; k++) begin
      in_data = 64'hA0 + 64'(k);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("drain3_occ", 64'(occupancy), 64'd0);
    chk("drain3_sb", 64'(sb.size()), 64'd0);

    // Flush the output stage while the consumer is ready.
    in_valid = 1'b1; in_data = 64'hB0; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    flush = 4'b1000;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tmp = sb.pop_front();
    tick();
    flush = 4'b0000;
    chk("flush_cnt_3", 64'(flush_count), 64'd3);
    chk("flush_out_occ", 64'(occupancy), 64'd0);

    // Reset mid-stream with three words resident.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 64'hC0 + 64'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_flush_cnt", 64'(flush_count), 64'd0);
    sb.delete();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hD0; tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("post_rst_early", 64'(out_valid), 64'd0);
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", out_data, 64'hD0);
    tick();
    chk("post_rst_sb", 64'(sb.size()), 64'd0);

    // Narrow counter: five live words flushed saturates at 3.
    v2 = 1'b1; d2 = 8'h01;
    @(posedge clk); #1;
    v2 = 1'b0; f2 = 4'b0001;
    @(posedge clk); #1;
    f2 = 4'b0000;
    #1;
    chk("sat_cnt_1", 64'(fc2), 64'd1);
    chk("sat_occ_0", 64'(occ2), 64'd0);
    v2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d2 = 8'(k + 2);
      @(posedge clk); #1;
    end
    v2 = 1'b0;
    #1;
    chk("sat_full_occ", 64'(occ2), 64'd4);
    chk("sat_full_ready", 64'(rdy2), 64'd0);
    f2 = 4'b1111;
    @(posedge clk); #1;
    f2 = 4'b0000;
    #1;
    chk("sat_cnt_3", 64'(fc2), 64'd3);
    chk("sat_all_flush_occ", 64'(occ2), 64'd0);
    chk("sat_out_valid", 64'(ov2), 64'd0);
    chk("sat_out_data", 64'(od2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
